// File: rtl/mux2_src_ctrl.sv
// Board-level stimulus source for mux2: two free-running square waves on a/b and
// a select line that toggles on each debounced press of an active-low key.
module mux2_src_ctrl #(
   parameter int A_HALF     = 10,
   parameter int B_HALF     = 20,
   parameter int DEB_CYCLES = 1000
) (
   input  logic sys_clk,
   input  logic sys_rst_n,
   input  logic key_in,
   output logic a,
   output logic b,
   output logic sl,
   output logic key_flag
);

   // state        | meaning
   // IDLE         | key released and stable
   // PRESS_WAIT   | key seen low, counting stable-low cycles
   // PRESSED      | press accepted, waiting for release
   // RELEASE_WAIT | key seen high, counting stable-high cycles
   typedef enum logic [1:0] {
      IDLE         = 2'd0,
      PRESS_WAIT   = 2'd1,
      PRESSED      = 2'd2,
      RELEASE_WAIT = 2'd3
   } state_t;

   localparam int AW = $clog2(A_HALF);
   localparam int BW = $clog2(B_HALF);
   localparam int DW = $clog2(DEB_CYCLES);

   localparam logic [AW-1:0] A_LAST = AW'(A_HALF - 1);
   localparam logic [BW-1:0] B_LAST = BW'(B_HALF - 1);
   // The edge that leaves IDLE/PRESSED is already the first stable sample, so the
   // wait state completes the DEB_CYCLES window one count early.
   localparam logic [DW-1:0] DEB_LAST = DW'(DEB_CYCLES - 2);

   logic [AW-1:0] cnt_a;
   logic [BW-1:0] cnt_b;
   logic [1:0]    key_sync;
   logic          key_s;
   state_t        state, state_nxt;
   logic [DW-1:0] deb_cnt, deb_nxt;
   logic          flag_nxt;

   always_ff @(posedge sys_clk) begin
      if (!sys_rst_n) begin
         cnt_a <= '0;
         a     <= 1'b0;
      end else if (cnt_a == A_LAST) begin
         cnt_a <= '0;
         a     <= ~a;
      end else begin
         cnt_a <= cnt_a + AW'(1);
      end
   end

   always_ff @(posedge sys_clk) begin
      if (!sys_rst_n) begin
         cnt_b <= '0;
         b     <= 1'b1;
      end else if (cnt_b == B_LAST) begin
         cnt_b <= '0;
         b     <= ~b;
      end else begin
         cnt_b <= cnt_b + BW'(1);
      end
   end

   always_ff @(posedge sys_clk) begin
      if (!sys_rst_n) begin
         key_sync <= 2'b11;
      end else begin
         key_sync <= {key_sync[0], key_in};
      end
   end

   assign key_s = key_sync[1];

   always_ff @(posedge sys_clk) begin
      if (!sys_rst_n) begin
         state    <= IDLE;
         deb_cnt  <= '0;
         key_flag <= 1'b0;
         sl       <= 1'b0;
      end else begin
         state    <= state_nxt;
         deb_cnt  <= deb_nxt;
         key_flag <= flag_nxt;
         sl       <= sl ^ flag_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      deb_nxt   = deb_cnt;
      flag_nxt  = 1'b0;
      case (state)
         IDLE: begin
            if (!key_s) begin
               state_nxt = PRESS_WAIT;
               deb_nxt   = '0;
            end
         end
         PRESS_WAIT: begin
            if (key_s) begin
               state_nxt = IDLE;
               deb_nxt   = '0;
            end else if (deb_cnt == DEB_LAST) begin
               state_nxt = PRESSED;
               deb_nxt   = '0;
               flag_nxt  = 1'b1;
            end else begin
               deb_nxt = deb_cnt + DW'(1);
            end
         end
         PRESSED: begin
            if (key_s) begin
               state_nxt = RELEASE_WAIT;
               deb_nxt   = '0;
            end
         end
         RELEASE_WAIT: begin
            if (!key_s) begin
               state_nxt = PRESSED;
               deb_nxt   = '0;
            end else if (deb_cnt == DEB_LAST) begin
               state_nxt = IDLE;
               deb_nxt   = '0;
            end else begin
               deb_nxt = deb_cnt + DW'(1);
            end
         end
         default: begin
            state_nxt = IDLE;
            deb_nxt   = '0;
         end
      endcase
   end

endmodule

// File: tb/tb_mux2_src_ctrl.sv
// Scoreboard bench for mux2_src_ctrl: directed key scenarios plus a random key
// phase; expected flag cycles are queued by the stimulus and consumed by a monitor.
module tb_mux2_src_ctrl;

   localparam int A_HALF = 10;
   localparam int B_HALF = 20;
   localparam int DEB    = 8;
   localparam int LAT    = 10;

   logic sys_clk   = 1'b0;
   logic sys_rst_n = 1'b0;
   logic key_in    = 1'b1;
   logic a, b, sl, key_flag;

   int checks = 0;
   int errors = 0;
   int cyc    = 0;
   int n      = 0;
   int exp_q[$];
   bit exp_sl = 1'b0;
   bit prev_sl = 1'b0;
   int flag_cnt = 0;
   int sl_tog   = 0;

   mux2_src_ctrl #(
      .A_HALF    (A_HALF),
      .B_HALF    (B_HALF),
      .DEB_CYCLES(DEB)
   ) dut (
      .sys_clk  (sys_clk),
      .sys_rst_n(sys_rst_n),
      .key_in   (key_in),
      .a        (a),
      .b        (b),
      .sl       (sl),
      .key_flag (key_flag)
   );

   initial forever #5 sys_clk = ~sys_clk;

   // n = edges since reset release; waves are a pure function of it
   initial begin
      bit ea, eb;
      int e;
      forever begin
         @(posedge sys_clk);
         cyc++;
         if (!sys_rst_n) begin
            n      = 0;
            exp_sl = 1'b0;
         end else begin
            n++;
         end
         @(negedge sys_clk);
         ea = ((n / A_HALF) % 2) == 1;
         eb = ((n / B_HALF) % 2) == 0;
         checks++;
         if (a !== ea) begin
            errors++;
            $display("FAIL wave_a cyc=%0d n=%0d got=%b want=%b", cyc, n, a, ea);
         end
         checks++;
         if (b !== eb) begin
            errors++;
            $display("FAIL wave_b cyc=%0d n=%0d got=%b want=%b", cyc, n, b, eb);
         end
         if (key_flag === 1'b1) begin
            flag_cnt++;
            checks++;
            if (exp_q.size() == 0) begin
               errors++;
               $display("FAIL key_flag_unexpected cyc=%0d got=1 want=0", cyc);
            end else begin
               e = exp_q.pop_front();
               if (e != cyc) begin
                  errors++;
                  $display("FAIL key_flag_cycle got=%0d want=%0d", cyc, e);
               end
            end
            exp_sl = ~exp_sl;
         end else if (key_flag !== 1'b0) begin
            checks++;
            errors++;
            $display("FAIL key_flag_x cyc=%0d got=%b want=0", cyc, key_flag);
         end
         checks++;
         if (sl !== exp_sl) begin
            errors++;
            $display("FAIL sl cyc=%0d got=%b want=%b", cyc, sl, exp_sl);
         end
         if (sl !== prev_sl) sl_tog++;
         prev_sl = sl;
      end
   end

   task automatic step(input int k);
      repeat (k) @(posedge sys_clk);
      #1;
   endtask

   task automatic press_expect();
      key_in = 1'b0;
      exp_q.push_back(cyc + LAT);
   endtask

   initial begin
      int f0, t0, pushes, start, len;
      bit v, pressed;

      // reset and free-running waves
      sys_rst_n = 1'b0;
      key_in    = 1'b1;
      step(5);
      sys_rst_n = 1'b1;
      step(45);

      // clean press held 30 cycles
      press_expect();
      step(30);
      key_in = 1'b1;
      step(20);

      // bouncy press
      repeat (4) begin
         key_in = 1'b0;
         step(3);
         key_in = 1'b1;
         step(2);
      end
      press_expect();
      step(30);

      // release bounce, then a clean press
      key_in = 1'b1;
      step(3);
      key_in = 1'b0;
      step(2);
      key_in = 1'b1;
      step(20);
      press_expect();
      step(20);
      key_in = 1'b1;
      step(20);

      // reset four cycles into PRESS_WAIT, key stays low
      key_in = 1'b0;
      step(7);
      sys_rst_n = 1'b0;
      step(3);
      sys_rst_n = 1'b1;
      exp_q.push_back(cyc + LAT);
      step(20);
      key_in = 1'b1;
      step(20);

      // random key activity: alternating runs, accepted when a run spans DEB samples
      f0      = flag_cnt;
      t0      = sl_tog;
      pushes  = 0;
      pressed = 1'b0;
      v       = 1'b0;
      start   = cyc;
      while (cyc < start + 10000) begin
         len    = $urandom_range(1, 12);
         key_in = v;
         if (!v && !pressed && len >= DEB) begin
            exp_q.push_back(cyc + LAT);
            pushes++;
            pressed = 1'b1;
         end else if (v && pressed && len >= DEB) begin
            pressed = 1'b0;
         end
         step(len);
         v = ~v;
      end
      key_in = 1'b1;
      step(20);

      checks++;
      if ((sl_tog - t0) != (flag_cnt - f0)) begin
         errors++;
         $display("FAIL rand_sl_toggles got=%0d want=%0d", sl_tog - t0, flag_cnt - f0);
      end
      checks++;
      if ((flag_cnt - f0) != pushes) begin
         errors++;
         $display("FAIL rand_flag_count got=%0d want=%0d", flag_cnt - f0, pushes);
      end
      checks++;
      if (exp_q.size() != 0) begin
         errors++;
         $display("FAIL missing_flags got=%0d pending want=0", exp_q.size());
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
